// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard / stall / flush controller for a 5-stage in-order pipeline.
//
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   id_rs1_i, id_rs2_i            source registers of the ID instruction
//   id_uses_rs1_i, id_uses_rs2_i  ID instruction actually reads rs1/rs2
//   id_ex_rd_i, id_ex_mem_read_i  rd of the EX instruction / EX is a load
//   ex_branch_taken_i             EX redirects the PC this cycle
//   ex_mc_start_i, mc_done_i      multi-cycle op issued / result ready (held)
//   dmem_req_i, dmem_ready_i      MEM-stage access pending / completing
//   *_stall_o                     hold PC or pipeline register (combinational)
//   *_flush_o                     load a bubble into the register (combinational)
//   mc_ack_o                      one-cycle acknowledge of mc_done_i
//   state_o                       FSM state (RUN=0, LU=1, MC_WAIT=2)
//   stall_cnt_o, flush_cnt_o      (PIPE_CTRL_PERF_EN only) saturating counters
module pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       id_ex_rd_i,
    input  logic             id_ex_mem_read_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_mc_start_i,
    input  logic             mc_done_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             id_ex_stall_o,
    output logic             ex_mm_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mm_flush_o,
    output logic             mm_wb_flush_o,
    output logic             mc_ack_o,
    output logic [1:0]       state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LU      = 2'd1,
        ST_MC_WAIT = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   mem_wait;
    logic   load_use;

    assign mem_wait = dmem_req_i && !dmem_ready_i;
    assign load_use = id_ex_mem_read_i && (id_ex_rd_i != 5'd0) &&
                      ((id_uses_rs1_i && (id_rs1_i == id_ex_rd_i)) ||
                       (id_uses_rs2_i && (id_rs2_i == id_ex_rd_i)));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and combinational stall/flush/ack; reset forces everything quiet
    always_comb begin
        state_d       = state_q;
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        id_ex_stall_o = 1'b0;
        ex_mm_stall_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        mm_wb_flush_o = 1'b0;
        mc_ack_o      = 1'b0;

        if (!rst_i) begin
            if (mem_wait) begin
                // Whole pipe frozen; a held mc_done_i is acked once the wait ends
                pc_stall_o    = 1'b1;
                if_id_stall_o = 1'b1;
                id_ex_stall_o = 1'b1;
                ex_mm_stall_o = 1'b1;
                mm_wb_flush_o = 1'b1;
            end else begin
                unique case (state_q)
                    ST_RUN: begin
                        if (ex_branch_taken_i) begin
                            // Redirect wins over load-use: the stalled instruction is squashed anyway
                            if_id_flush_o = 1'b1;
                            id_ex_flush_o = 1'b1;
                        end else if (ex_mc_start_i) begin
                            state_d = ST_MC_WAIT;
                        end else if (load_use) begin
                            pc_stall_o    = 1'b1;
                            if_id_stall_o = 1'b1;
                            id_ex_flush_o = 1'b1;
                            state_d       = ST_LU;
                        end
                    end
                    ST_LU: begin
                        // Bubble in EX: no load-use re-detection, one cycle only
                        if (ex_branch_taken_i) begin
                            if_id_flush_o = 1'b1;
                            id_ex_flush_o = 1'b1;
                        end
                        state_d = ST_RUN;
                    end
                    ST_MC_WAIT: begin
                        if (mc_done_i) begin
                            mc_ack_o = 1'b1;
                            state_d  = ST_RUN;
                        end else begin
                            pc_stall_o    = 1'b1;
                            if_id_stall_o = 1'b1;
                            id_ex_stall_o = 1'b1;
                            ex_mm_stall_o = 1'b1;
                            mm_wb_flush_o = 1'b1;
                        end
                    end
                    default: state_d = ST_RUN;
                endcase
            end
        end
    end

    assign ex_mm_flush_o = 1'b0;
    assign state_o       = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (if_id_flush_o && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    logic [CNT_W-1:0] perf_unused;
    assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written
// reset / saturation sequences, and randomized traffic against a rule model.
module tb_pipe_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1, u2, mr, br, mcs, mcd, dreq, drdy;
    } in_t;

    // stall = {pc, if_id, id_ex, ex_mm}; flush = {if_id, id_ex, ex_mm, mm_wb}
    typedef struct packed {
        logic [3:0] stall;
        logic [3:0] flush;
        logic       ack;
        logic [1:0] st;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_ex_rd_i;
    logic       id_uses_rs1_i, id_uses_rs2_i, id_ex_mem_read_i;
    logic       ex_branch_taken_i, ex_mc_start_i, mc_done_i;
    logic       dmem_req_i, dmem_ready_i;
    logic       pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mm_stall_o;
    logic       if_id_flush_o, id_ex_flush_o, ex_mm_flush_o, mm_wb_flush_o;
    logic       mc_ack_o;
    logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .id_ex_rd_i(id_ex_rd_i), .id_ex_mem_read_i(id_ex_mem_read_i),
        .ex_branch_taken_i(ex_branch_taken_i),
        .ex_mc_start_i(ex_mc_start_i), .mc_done_i(mc_done_i),
        .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
        .id_ex_stall_o(id_ex_stall_o), .ex_mm_stall_o(ex_mm_stall_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
        .ex_mm_flush_o(ex_mm_flush_o), .mm_wb_flush_o(mm_wb_flush_o),
        .mc_ack_o(mc_ack_o), .state_o(state_o)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: pipeline mode (0 run, 1 one-bubble, 2 waiting on mul/div)
    int m_st   = 0;
    int m_scnt = 0;
    int m_fcnt = 0;

    function automatic out_t model_out(int st, in_t x, logic r);
        out_t o;
        bit   frozen, hazard;
        o        = '0;
        o.st     = 2'(st);
        if (r) return '0;
        frozen   = x.dreq && !x.drdy;
        hazard   = x.mr && (x.rd != 0) &&
                   ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
        if (frozen || (st == 2 && !x.mcd)) begin
            o.stall = 4'b1111;
            o.flush = 4'b0001;
        end else if (st == 2) begin
            o.ack = 1'b1;
        end else if (x.br) begin
            o.flush = 4'b1100;
        end else if (st == 0 && !x.mcs && hazard) begin
            o.stall = 4'b1100;
            o.flush = 4'b0100;
        end
        return o;
    endfunction

    function automatic int model_next(int st, in_t x);
        bit hazard;
        hazard = x.mr && (x.rd != 0) &&
                 ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
        if (x.dreq && !x.drdy) return st;
        if (st == 2) return x.mcd ? 0 : 2;
        if (st == 1) return 0;
        if (x.br)    return 0;
        if (x.mcs)   return 2;
        return hazard ? 1 : 0;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.stall = {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mm_stall_o};
        o.flush = {if_id_flush_o, id_ex_flush_o, ex_mm_flush_o, mm_wb_flush_o};
        o.ack   = mc_ack_o;
        o.st    = state_o;
        return o;
    endfunction

    task automatic check_out(input string nm, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got stall=%b flush=%b ack=%b st=%0d, expected stall=%b flush=%b ack=%b st=%0d",
                     nm, got.stall, got.flush, got.ack, got.st,
                     exp.stall, exp.flush, exp.ack, exp.st);
        end
    endtask

    task automatic check_val(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input in_t x, input logic r);
        rst_i             = r;
        id_rs1_i          = x.rs1;
        id_rs2_i          = x.rs2;
        id_ex_rd_i        = x.rd;
        id_uses_rs1_i     = x.u1;
        id_uses_rs2_i     = x.u2;
        id_ex_mem_read_i  = x.mr;
        ex_branch_taken_i = x.br;
        ex_mc_start_i     = x.mcs;
        mc_done_i         = x.mcd;
        dmem_req_i        = x.dreq;
        dmem_ready_i      = x.drdy;
    endtask

    // One clock: drive after the edge, sample mid-cycle, advance the model
    task automatic step(input in_t x, input logic r, output out_t got, output out_t exp);
        @(posedge clk_i);
        #1;
        drive(x, r);
        #3;
        got = dut_out();
        exp = model_out(m_st, x, r);
`ifdef PIPE_CTRL_PERF_EN
        check_val("stall_cnt", int'(stall_cnt_o), r ? 0 : m_scnt);
        check_val("flush_cnt", int'(flush_cnt_o), r ? 0 : m_fcnt);
`endif
        if (r) begin
            m_st = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (exp.stall[3] && m_scnt < CNT_MAX) m_scnt++;
            if (exp.flush[3] && m_fcnt < CNT_MAX) m_fcnt++;
            m_st = model_next(m_st, x);
        end
    endtask

    function automatic in_t mk_in(int rs1, int rs2, int rd, bit u1, bit u2, bit mr,
                                  bit br, bit mcs, bit mcd, bit dreq, bit drdy);
        in_t x;
        x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.rd = 5'(rd);
        x.u1 = u1; x.u2 = u2; x.mr = mr; x.br = br;
        x.mcs = mcs; x.mcd = mcd; x.dreq = dreq; x.drdy = drdy;
        return x;
    endfunction

    function automatic out_t mk_out(logic [3:0] s, logic [3:0] f, bit a, int st);
        out_t o;
        o.stall = s; o.flush = f; o.ack = a; o.st = 2'(st);
        return o;
    endfunction

    vec_t tbl[$];

    task automatic add(input in_t x, input out_t o);
        vec_t v;
        v.i = x; v.o = o;
        tbl.push_back(v);
    endtask

    initial begin : main
        in_t  idle, ld5, mwait, x;
        out_t got, exp, zero, frz;

        idle  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ld5   = mk_in(5, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0);
        mwait = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        zero  = '0;
        frz   = mk_out(4'b1111, 4'b0001, 0, 0);

        // rs1, rs2, rd, u1, u2, mr, br, mcs, mcd, dreq, drdy -> stall, flush, ack, state
        add(idle,                                          mk_out(4'b0000, 4'b0000, 0, 0));
        add(ld5,                                           mk_out(4'b1100, 4'b0100, 0, 0));
        add(ld5,                                           mk_out(4'b0000, 4'b0000, 0, 1));
        add(idle,                                          mk_out(4'b0000, 4'b0000, 0, 0));
        add(mk_in(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0),        mk_out(4'b0000, 4'b0000, 0, 0));
        add(mk_in(1, 9, 9, 1, 1, 1, 0, 0, 0, 0, 0),        mk_out(4'b1100, 4'b0100, 0, 0));
        add(idle,                                          mk_out(4'b0000, 4'b0000, 0, 1));
        add(mk_in(6, 2, 6, 0, 1, 1, 0, 0, 0, 0, 0),        mk_out(4'b0000, 4'b0000, 0, 0));
        add(mk_in(5, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0),        mk_out(4'b0000, 4'b1100, 0, 0));
        add(idle,                                          mk_out(4'b0000, 4'b0000, 0, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),        mk_out(4'b0000, 4'b0000, 0, 0));
        add(idle,                                          mk_out(4'b1111, 4'b0001, 0, 2));
        add(mk_in(5, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0),        mk_out(4'b1111, 4'b0001, 0, 2));
        add(idle,                                          mk_out(4'b1111, 4'b0001, 0, 2));
        add(idle,                                          mk_out(4'b1111, 4'b0001, 0, 2));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),        mk_out(4'b0000, 4'b0000, 1, 2));
        add(idle,                                          mk_out(4'b0000, 4'b0000, 0, 0));
        add(mk_in(5, 0, 5, 1, 0, 1, 1, 0, 0, 1, 0),        mk_out(4'b1111, 4'b0001, 0, 0));
        add(mk_in(5, 0, 5, 1, 0, 1, 0, 0, 0, 1, 0),        mk_out(4'b1111, 4'b0001, 0, 0));
        add(mk_in(5, 0, 5, 1, 0, 1, 0, 0, 0, 1, 1),        mk_out(4'b1100, 4'b0100, 0, 0));
        add(mwait,                                         mk_out(4'b1111, 4'b0001, 0, 1));
        add(idle,                                          mk_out(4'b0000, 4'b0000, 0, 1));
        add(idle,                                          mk_out(4'b0000, 4'b0000, 0, 0));
        // multi-cycle op overlapped by a 3-cycle memory wait, done rising mid-wait
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),        mk_out(4'b0000, 4'b0000, 0, 0));
        add(idle,                                          mk_out(4'b1111, 4'b0001, 0, 2));
        add(mwait,                                         mk_out(4'b1111, 4'b0001, 0, 2));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0),        mk_out(4'b1111, 4'b0001, 0, 2));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0),        mk_out(4'b1111, 4'b0001, 0, 2));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1),        mk_out(4'b0000, 4'b0000, 1, 2));
        add(idle,                                          mk_out(4'b0000, 4'b0000, 0, 0));

        // Reset held with a memory wait on the inputs: everything stays quiet
        drive(mwait, 1'b1);
        step(mwait, 1'b1, got, exp);
        check_out("reset_quiet", got, zero);
        step(mwait, 1'b1, got, exp);
        check_out("reset_quiet2", got, zero);

        foreach (tbl[k]) begin
            step(tbl[k].i, 1'b0, got, exp);
            check_out($sformatf("vec%0d", k), got, tbl[k].o);
        end

        // Randomized traffic against the rule model
        for (int n = 0; n < 800; n++) begin
            x.rs1  = 5'($urandom_range(0, 3));
            x.rs2  = 5'($urandom_range(0, 3));
            x.rd   = 5'($urandom_range(0, 3));
            x.u1   = 1'($urandom_range(0, 1));
            x.u2   = 1'($urandom_range(0, 1));
            x.mr   = 1'($urandom_range(0, 1));
            x.br   = ($urandom_range(0, 7) == 0);
            x.mcs  = ($urandom_range(0, 5) == 0);
            x.mcd  = ($urandom_range(0, 2) == 0);
            x.dreq = ($urandom_range(0, 3) == 0);
            x.drdy = 1'($urandom_range(0, 1));
            step(x, 1'b0, got, exp);
            check_out("rand", got, exp);
        end

        // Asynchronous reset in the middle of a multi-cycle wait
        step(idle, 1'b1, got, exp);
        step(idle, 1'b0, got, exp);
        check_out("mc_pre", got, zero);
        step(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0, got, exp);
        step(idle, 1'b0, got, exp);
        check_out("mc_wait", got, mk_out(4'b1111, 4'b0001, 0, 2));
        #1;
        rst_i     = 1'b1;
        mc_done_i = 1'b1;
        #1;
        check_out("mc_async_rst", dut_out(), zero);
        m_st = 0; m_scnt = 0; m_fcnt = 0;
        x = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(x, 1'b1, got, exp);
        check_out("mc_rst_hold", got, zero);
        step(x, 1'b0, got, exp);
        check_out("mc_no_ack1", got, zero);
        step(x, 1'b0, got, exp);
        check_out("mc_no_ack2", got, zero);

        // Asynchronous reset during the load-use bubble
        step(ld5, 1'b0, got, exp);
        check_out("lu_stall", got, mk_out(4'b1100, 4'b0100, 0, 0));
        step(idle, 1'b0, got, exp);
        check_out("lu_state", got, mk_out(4'b0000, 4'b0000, 0, 1));
        #1;
        rst_i = 1'b1;
        #1;
        check_out("lu_async_rst", dut_out(), zero);
        m_st = 0; m_scnt = 0; m_fcnt = 0;
        step(idle, 1'b1, got, exp);
        step(idle, 1'b0, got, exp);
        check_out("lu_after_rst", got, zero);

        // Counter exercise: three taken branches, then a long memory freeze
        for (int n = 0; n < 3; n++) begin
            step(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0, got, exp);
            check_out("br_flush", got, mk_out(4'b0000, 4'b1100, 0, 0));
        end
        for (int n = 0; n < 20; n++) begin
            step(mwait, 1'b0, got, exp);
            check_out("freeze", got, frz);
        end
        step(idle, 1'b0, got, exp);
        check_out("after_freeze", got, zero);
`ifdef PIPE_CTRL_PERF_EN
        check_val("flush_cnt_3", int'(flush_cnt_o), 3);
        check_val("stall_cnt_sat", int'(stall_cnt_o), 15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
